// File: rtl/vga_pkg.sv
// Shared timing defaults, phase-state encoding and coordinate type for the
// VGA sync generator and its phase counters.
package vga_pkg;

   // 640x480@60 with a 25 MHz pixel tick
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FRONT_DEF  = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BACK_DEF   = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FRONT_DEF  = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BACK_DEF   = 33;

   localparam int COORD_W   = 10;
   localparam int COORD_MAX = 1023;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      ACT  = 2'd0,
      FP   = 2'd1,
      SYNC = 2'd2,
      BP   = 2'd3
   } phase_t;

   // Phase order within one line or one frame
   function automatic phase_t next_phase(input phase_t p);
      phase_t n;
      case (p)
         ACT:     n = FP;
         FP:      n = SYNC;
         SYNC:    n = BP;
         BP:      n = ACT;
         default: n = ACT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle between the sync generator and its consumers (connector
// pins and pixel-colour logic). pix_en comes from the clock divider.
interface vga_sync_gen_if;
   import vga_pkg::*;

   logic   pix_en;
   logic   hsync;
   logic   vsync;
   logic   video_on;
   coord_t x;
   coord_t y;
   logic   line_start;
   logic   frame_start;

   modport master (
      input  pix_en,
      output hsync, vsync, video_on, x, y, line_start, frame_start
   );

   modport slave (
      input  pix_en, hsync, vsync, video_on, x, y, line_start, frame_start
   );

endinterface

// File: rtl/vga_phase_counter.sv
// Four-phase (active / front porch / sync / back porch) sequencer with a
// position counter. Used once per axis; wrap flags the step that returns
// the position to 0.
module vga_phase_counter
   import vga_pkg::*;
#(
   parameter int P_ACT  = H_ACTIVE_DEF,
   parameter int P_FP   = H_FRONT_DEF,
   parameter int P_SYNC = H_SYNC_DEF,
   parameter int P_BP   = H_BACK_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   step,
   output phase_t state,
   output coord_t pos,
   output logic   in_sync,
   output logic   wrap
);

   localparam int TOTAL = P_ACT + P_FP + P_SYNC + P_BP;

   if ((TOTAL > COORD_MAX) || (P_ACT < 1) || (P_FP < 1) || (P_SYNC < 1) || (P_BP < 1)) begin : g_illegal
      $error("vga_phase_counter: phase lengths must be >= 1 and total <= 1023");
   end

   phase_t state_r;
   coord_t phase_cnt_r;
   coord_t pos_r;
   logic   sync_r;
   logic   phase_last_s;

   // Index of the final tick of a phase
   function automatic coord_t phase_last_idx(input phase_t p);
      coord_t n;
      case (p)
         ACT:     n = coord_t'(P_ACT - 1);
         FP:      n = coord_t'(P_FP - 1);
         SYNC:    n = coord_t'(P_SYNC - 1);
         BP:      n = coord_t'(P_BP - 1);
         default: n = coord_t'(P_ACT - 1);
      endcase
      return n;
   endfunction

   // Flag the last tick of the current phase
   always_comb begin
      phase_last_s = (phase_cnt_r == phase_last_idx(state_r));
   end

   // The end of the back porch is the end of the line/frame
   assign wrap = step && (state_r == BP) && phase_last_s;

   // Phase FSM, phase counter, position and registered sync flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ACT;
         phase_cnt_r <= 10'd0;
         pos_r       <= 10'd0;
         sync_r      <= 1'b0;
      end else if (step) begin
         if ((state_r == BP) && phase_last_s) begin
            pos_r <= 10'd0;
         end else begin
            pos_r <= pos_r + 10'd1;
         end
         if (phase_last_s) begin
            state_r     <= next_phase(state_r);
            phase_cnt_r <= 10'd0;
            sync_r      <= (next_phase(state_r) == SYNC);
         end else begin
            phase_cnt_r <= phase_cnt_r + 10'd1;
         end
      end
   end

   assign state   = state_r;
   assign pos     = pos_r;
   assign in_sync = sync_r;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: horizontal and vertical phase counters advanced by
// the pixel tick, producing sync pins, coordinates, active-video flag and
// line/frame start pulses.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FRONT  = H_FRONT_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BACK   = H_BACK_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FRONT  = V_FRONT_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BACK   = V_BACK_DEF,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   vga_sync_gen_if.master  bus
);

   phase_t h_state_s;
   phase_t v_state_s;
   coord_t h_pos_s;
   coord_t v_pos_s;
   logic   h_sync_s;
   logic   v_sync_s;
   logic   h_wrap_s;
   logic   v_wrap_s;
   logic   v_step_s;
   logic   line_start_r;
   logic   frame_start_r;

   // The vertical axis moves only on the tick that ends a line
   assign v_step_s = bus.pix_en && h_wrap_s;

   vga_phase_counter #(
      .P_ACT  (H_ACTIVE),
      .P_FP   (H_FRONT),
      .P_SYNC (H_SYNC),
      .P_BP   (H_BACK)
   ) u_h (
      .clk     (clk),
      .rst     (rst),
      .step    (bus.pix_en),
      .state   (h_state_s),
      .pos     (h_pos_s),
      .in_sync (h_sync_s),
      .wrap    (h_wrap_s)
   );

   vga_phase_counter #(
      .P_ACT  (V_ACTIVE),
      .P_FP   (V_FRONT),
      .P_SYNC (V_SYNC),
      .P_BP   (V_BACK)
   ) u_v (
      .clk     (clk),
      .rst     (rst),
      .step    (v_step_s),
      .state   (v_state_s),
      .pos     (v_pos_s),
      .in_sync (v_sync_s),
      .wrap    (v_wrap_s)
   );

   // One-clock pulses in the cycle after the position wraps to 0 / (0,0)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         line_start_r  <= h_wrap_s;
         frame_start_r <= h_wrap_s && v_wrap_s;
      end
   end

   assign bus.hsync       = h_sync_s ? SYNC_POL : ~SYNC_POL;
   assign bus.vsync       = v_sync_s ? SYNC_POL : ~SYNC_POL;
   assign bus.video_on    = (h_state_s == ACT) && (v_state_s == ACT);
   assign bus.x           = h_pos_s;
   assign bus.y           = v_pos_s;
   assign bus.line_start  = line_start_r;
   assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a shrunken-timing
// instance (15x9 frame) run side by side from a shared tick and reset.
module tb_vga_sync_gen;
   import vga_pkg::*;

   localparam int FH_T = 800;
   localparam int FV_T = 525;
   localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
   localparam int SV_A = 5, SV_F = 1, SV_S = 2, SV_B = 1;
   localparam int SH_T = SH_A + SH_F + SH_S + SH_B;
   localparam int SV_T = SV_A + SV_F + SV_S + SV_B;

   logic clk = 1'b0;
   logic rst;
   logic pix_en;

   vga_sync_gen_if bus_f ();
   vga_sync_gen_if bus_s ();
   assign bus_f.pix_en = pix_en;
   assign bus_s.pix_en = pix_en;

   vga_sync_gen dut_f (.clk(clk), .rst(rst), .bus(bus_f));

   vga_sync_gen #(
      .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
      .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
      .SYNC_POL(1'b0)
   ) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

   always #5 clk = ~clk;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       von;
      logic       ls;
      logic       fs;
      logic [9:0] x;
      logic [9:0] y;
   } obs_t;

   typedef struct {
      int ticks;
      int period;
      int fx;
      int fy;
      int sx;
      int sy;
   } vec_t;

   vec_t tbl [6];
   obs_t q_f [$];
   obs_t q_s [$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // model positions and pending pulses
   int fx = 0, fy = 0, sx = 0, sy = 0;
   bit fls = 1'b0, ffs = 1'b0, sls = 1'b0, sfs = 1'b0;

   // observed statistics
   int f_hlow, f_hlow_minx, f_hlow_maxx, f_ls, f_fs;
   int s_hlow, s_vlow, s_vlow_miny, s_vlow_maxy, s_ls, s_fs;
   int f_ls_cyc [$];

   function automatic obs_t expect_obs(input int x, input int y, input bit ls, input bit fs,
                                       input int ha, input int hf, input int hsw,
                                       input int va, input int vf, input int vsw);
      obs_t o;
      o.hs  = !((x >= ha + hf) && (x < ha + hf + hsw));
      o.vs  = !((y >= va + vf) && (y < va + vf + vsw));
      o.von = (x < ha) && (y < va);
      o.ls  = ls;
      o.fs  = fs;
      o.x   = 10'(x);
      o.y   = 10'(y);
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic model_step(input bit en, inout int x, inout int y, output bit ls, output bit fs,
                             input int ht, input int vt);
      if (rst) begin
         x = 0; y = 0; ls = 1'b0; fs = 1'b0;
      end else if (en) begin
         ls = (x == ht - 1);
         fs = ls && (y == vt - 1);
         x  = ls ? 0 : x + 1;
         if (ls) y = (y == vt - 1) ? 0 : y + 1;
      end else begin
         ls = 1'b0; fs = 1'b0;
      end
   endtask

   task automatic clear_stats();
      f_hlow = 0; f_hlow_minx = 1023; f_hlow_maxx = -1; f_ls = 0; f_fs = 0;
      s_hlow = 0; s_vlow = 0; s_vlow_miny = 1023; s_vlow_maxy = -1; s_ls = 0; s_fs = 0;
      f_ls_cyc.delete();
   endtask

   // one clock: drive, predict, let the edge happen, compare, collect stats
   task automatic clk_step(input bit en);
      obs_t a;
      obs_t e;
      pix_en = en;
      model_step(en, fx, fy, fls, ffs, FH_T, FV_T);
      q_f.push_back(expect_obs(fx, fy, fls, ffs, 640, 16, 96, 480, 10, 2));
      model_step(en, sx, sy, sls, sfs, SH_T, SV_T);
      q_s.push_back(expect_obs(sx, sy, sls, sfs, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S));
      @(posedge clk);
      #1;
      cyc++;
      a = {bus_f.hsync, bus_f.vsync, bus_f.video_on, bus_f.line_start, bus_f.frame_start, bus_f.x, bus_f.y};
      e = q_f.pop_front();
      check("cycle_full", 32'(a), 32'(e));
      if (en && !bus_f.hsync) begin
         f_hlow++;
         if (int'(bus_f.x) < f_hlow_minx) f_hlow_minx = int'(bus_f.x);
         if (int'(bus_f.x) > f_hlow_maxx) f_hlow_maxx = int'(bus_f.x);
      end
      if (bus_f.line_start) begin
         f_ls++;
         f_ls_cyc.push_back(cyc);
      end
      if (bus_f.frame_start) f_fs++;
      a = {bus_s.hsync, bus_s.vsync, bus_s.video_on, bus_s.line_start, bus_s.frame_start, bus_s.x, bus_s.y};
      e = q_s.pop_front();
      check("cycle_small", 32'(a), 32'(e));
      if (en && !bus_s.hsync) s_hlow++;
      if (en && !bus_s.vsync) begin
         s_vlow++;
         if (int'(bus_s.y) < s_vlow_miny) s_vlow_miny = int'(bus_s.y);
         if (int'(bus_s.y) > s_vlow_maxy) s_vlow_maxy = int'(bus_s.y);
      end
      if (bus_s.line_start) s_ls++;
      if (bus_s.frame_start) s_fs++;
      @(negedge clk);
   endtask

   // n ticks, one every 'period' clocks; period 0 means n idle clocks
   task automatic run_ticks(input int n, input int period);
      for (int i = 0; i < n; i++) begin
         if (period == 0) begin
            clk_step(1'b0);
         end else begin
            for (int j = 0; j < period - 1; j++) clk_step(1'b0);
            clk_step(1'b1);
         end
      end
   endtask

   // reset asserted between clock edges must act at once
   task automatic apply_reset_async(input string tag);
      obs_t a;
      #2;
      rst = 1'b1;
      #1;
      a = {bus_f.hsync, bus_f.vsync, bus_f.video_on, bus_f.line_start, bus_f.frame_start, bus_f.x, bus_f.y};
      check({tag, "_full"}, 32'(a), 32'(expect_obs(0, 0, 1'b0, 1'b0, 640, 16, 96, 480, 10, 2)));
      a = {bus_s.hsync, bus_s.vsync, bus_s.video_on, bus_s.line_start, bus_s.frame_start, bus_s.x, bus_s.y};
      check({tag, "_small"}, 32'(a), 32'(expect_obs(0, 0, 1'b0, 1'b0, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S)));
      clk_step(1'b1);
      clk_step(1'b1);
      rst = 1'b0;
   endtask

   initial begin
      obs_t a;
      tbl[0] = '{10,  2, 10,  0, 10, 0};
      tbl[1] = '{700, 1, 710, 0, 5,  2};
      tbl[2] = '{90,  3, 0,   1, 5,  8};
      tbl[3] = '{37,  1, 37,  1, 12, 1};
      tbl[4] = '{50,  0, 37,  1, 12, 1};
      tbl[5] = '{763, 1, 0,   2, 10, 7};

      rst    = 1'b1;
      pix_en = 1'b0;
      clear_stats();
      repeat (3) @(negedge clk);
      a = {bus_f.hsync, bus_f.vsync, bus_f.video_on, bus_f.line_start, bus_f.frame_start, bus_f.x, bus_f.y};
      check("reset_full", 32'(a), 32'(expect_obs(0, 0, 1'b0, 1'b0, 640, 16, 96, 480, 10, 2)));
      a = {bus_s.hsync, bus_s.vsync, bus_s.video_on, bus_s.line_start, bus_s.frame_start, bus_s.x, bus_s.y};
      check("reset_small", 32'(a), 32'(expect_obs(0, 0, 1'b0, 1'b0, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S)));
      rst = 1'b0;

      // table of tick bursts with hand-computed end positions
      for (int i = 0; i < 6; i++) begin
         run_ticks(tbl[i].ticks, tbl[i].period);
         check($sformatf("vec%0d_full_x", i),  32'(bus_f.x), 32'(tbl[i].fx));
         check($sformatf("vec%0d_full_y", i),  32'(bus_f.y), 32'(tbl[i].fy));
         check($sformatf("vec%0d_small_x", i), 32'(bus_s.x), 32'(tbl[i].sx));
         check($sformatf("vec%0d_small_y", i), 32'(bus_s.y), 32'(tbl[i].sy));
      end

      // two full lines at half rate: hsync window and line period
      clear_stats();
      run_ticks(1600, 2);
      check("hsync_low_ticks", 32'(f_hlow), 32'd192);
      check("hsync_low_minx",  32'(f_hlow_minx), 32'd656);
      check("hsync_low_maxx",  32'(f_hlow_maxx), 32'd751);
      check("line_start_full", 32'(f_ls), 32'd2);
      if (f_ls_cyc.size() == 2)
         check("line_period_clk", 32'(f_ls_cyc[1] - f_ls_cyc[0]), 32'd1600);
      check("frame_start_full", 32'(f_fs), 32'd0);
      check("line_start_small", 32'(s_ls), 32'd107);
      check("frame_start_small", 32'(s_fs), 32'd12);
      check("win_full_xy",  32'({bus_f.x, bus_f.y}), 32'({10'd0, 10'd4}));
      check("win_small_xy", 32'({bus_s.x, bus_s.y}), 32'({10'd5, 10'd6}));

      // reset mid-stream, then one whole small frame with back-to-back ticks
      apply_reset_async("rst_mid");
      clear_stats();
      run_ticks(SH_T * SV_T, 1);
      check("vsync_low_ticks", 32'(s_vlow), 32'd30);
      check("vsync_low_miny",  32'(s_vlow_miny), 32'd6);
      check("vsync_low_maxy",  32'(s_vlow_maxy), 32'd7);
      check("hsync_low_small", 32'(s_hlow), 32'd27);
      check("frame_lines",     32'(s_ls), 32'd9);
      check("frame_once",      32'(s_fs), 32'd1);
      check("frame_end_xy",    32'({bus_s.x, bus_s.y}), 32'({10'd0, 10'd0}));
      check("frame_full_xy",   32'({bus_f.x, bus_f.y}), 32'({10'd135, 10'd0}));

      // freeze on the last active pixel, then step past it
      run_ticks(67, 1);
      clear_stats();
      run_ticks(100, 0);
      check("hold_xy",    32'({bus_s.x, bus_s.y}), 32'({10'd7, 10'd4}));
      check("hold_von",   32'(bus_s.video_on), 32'd1);
      check("hold_pulse", 32'(s_ls + f_ls), 32'd0);
      run_ticks(1, 1);
      check("after_hold_x",   32'(bus_s.x), 32'd8);
      check("after_hold_von", 32'(bus_s.video_on), 32'd0);

      // reset mid-frame, then one full line of the default timing
      apply_reset_async("rst_frame");
      clear_stats();
      run_ticks(800, 1);
      check("restart_full_xy", 32'({bus_f.x, bus_f.y}), 32'({10'd0, 10'd1}));
      check("restart_no_fs",   32'(f_fs), 32'd0);
      check("restart_ls",      32'(f_ls), 32'd1);
      check("restart_small_xy", 32'({bus_s.x, bus_s.y}), 32'({10'd5, 10'd8}));
      check("restart_small_fs", 32'(s_fs), 32'd5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates VGA horizontal/vertical sync, pixel coordinates and active-video flag from a single system clock, advanced by a one-cycle pixel-enable pulse produced by the codebase's clock divider (50 MHz / 2 → 25 MHz tick for 640x480@60). It consumes the divided timing base and drives the VGA connector sync pins and the pixel-colour logic downstream.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 1'b0, asserted level of hsync/vsync (0 = active-low)

- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel tick; one-clk pulse, all state advances only when high
- hsync  out  1  horizontal sync, level SYNC_POL during sync phase
- vsync  out  1  vertical sync, level SYNC_POL during sync lines
- video_on  out  1  high when both H and V are in active phase
- x  out  10  horizontal count, 0..H_TOTAL-1
- y  out  10  vertical count, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse after h counter wraps to 0
- frame_start  out  1  one-clk pulse after (x,y) wraps to (0,0)

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- Horizontal FSM states: H_ACT → H_FP → H_SYNC → H_BP → H_ACT; each state lasts its parameter count of pix_en ticks, tracked by a phase counter reloaded on transition.
- Vertical FSM identical (V_ACT, V_FP, V_SYNC, V_BP) but advances only on the pix_en tick where x = H_TOTAL-1.
- x increments each pix_en, wraps H_TOTAL-1 → 0; y increments on x wrap, wraps V_TOTAL-1 → 0.
- hsync = SYNC_POL iff H state is H_SYNC (x = 656..751 at defaults), else ~SYNC_POL; vsync likewise (y = 490..491).
- video_on = (H state == H_ACT) && (V state == V_ACT), i.e. x<640 && y<480.
- pix_en low: all counters, states and outputs hold; pulses stay low.
- Reset values: x=0, y=0, both FSMs in ACT, hsync=vsync=~SYNC_POL, video_on=1, line_start=0, frame_start=0.
- Reset mid-frame: all state returns to reset values asynchronously; counting resumes from (0,0) on first pix_en after release; no frame_start for that restart.
- Counter widths 10 bits; parameters whose totals exceed 1023 are illegal (elaboration assertion).

## Timing
- hsync, vsync, x, y, FSM states registered; update on the clk edge where pix_en=1; video_on decoded from registered states (zero added latency).
- hsync/vsync/video_on/x/y are mutually coherent: all describe the same pixel in the same cycle.
- line_start: registered, high exactly one clk in the cycle after the edge where x went H_TOTAL-1 → 0; frame_start same, only when y also went V_TOTAL-1 → 0 (line_start also high then).
- Back-to-back pix_en (every cycle) is legal; pulses then still last one clk.

## Structure
- Package vga_pkg: default timing constants (640x480@60), phase-state enum {ACT, FP, SYNC, BP}, 10-bit coordinate typedef.
- Sub-module vga_phase_counter: generic four-phase FSM + position counter with step enable and wrap flag; instantiated once for H (step = pix_en) and once for V (step = pix_en && h wrap).

## Test plan
- Assert rst mid-stream → immediately x=0, y=0, hsync=1, vsync=1, video_on=1, pulses 0.
- Release rst, pix_en every 2nd clk → hsync low exactly for x=656..751 (96 ticks), line period 800 ticks (1600 clk).
- Run to y=489→490 → vsync low for y=490 and 491 only (1600 ticks), high at y=492.
- Full frame, 420000 pix_en → frame_start single-clk pulse once, x=0,y=0; line_start 525 pulses.
- Hold pix_en low 100 clk at x=639,y=479 → all outputs frozen, video_on=1; next tick x=640, video_on=0.
- Reset at x=700,y=300, release, 800 ticks → x=0,y=1, no frame_start seen.
